// File: rtl/pong_chars_pkg.sv
// Shared character codes, controller state encoding, row layouts and BCD helpers
// used by the score banner controller and its score counters.
package pong_chars_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int CODE_W    = 6;

  typedef logic [CODE_W-1:0] char_t;

  localparam char_t CH_0 = 6'd0, CH_1 = 6'd1, CH_2 = 6'd2, CH_3 = 6'd3, CH_4 = 6'd4;
  localparam char_t CH_5 = 6'd5, CH_6 = 6'd6, CH_7 = 6'd7, CH_8 = 6'd8, CH_9 = 6'd9;
  localparam char_t CH_A = 6'd10, CH_B = 6'd11, CH_C = 6'd12, CH_D = 6'd13, CH_E = 6'd14;
  localparam char_t CH_F = 6'd15, CH_G = 6'd16, CH_H = 6'd17, CH_I = 6'd18, CH_J = 6'd19;
  localparam char_t CH_K = 6'd20, CH_L = 6'd21, CH_M = 6'd22, CH_N = 6'd23, CH_O = 6'd24;
  localparam char_t CH_P = 6'd25, CH_Q = 6'd26, CH_R = 6'd27, CH_S = 6'd28, CH_T = 6'd29;
  localparam char_t CH_U = 6'd30, CH_V = 6'd31, CH_W = 6'd32, CH_X = 6'd33, CH_Y = 6'd34;
  localparam char_t CH_Z = 6'd35;
  localparam char_t CH_SPACE = 6'd36;
  localparam char_t CH_QMARK = 6'd63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    FLASH = 2'd2,
    WIN   = 2'd3
  } state_t;

  // Layouts are packed with slot 0 in the least significant character.
  localparam logic [NUM_SLOTS*CODE_W-1:0] TITLE_CODES =
    {CH_SPACE, CH_SPACE, CH_SPACE, CH_G, CH_N, CH_O, CH_P, CH_SPACE};
  localparam logic [NUM_SLOTS*CODE_W-1:0] WIN_P1_CODES =
    {CH_SPACE, CH_S, CH_N, CH_I, CH_W, CH_SPACE, CH_1, CH_P};
  localparam logic [NUM_SLOTS*CODE_W-1:0] WIN_P2_CODES =
    {CH_SPACE, CH_S, CH_N, CH_I, CH_W, CH_SPACE, CH_2, CH_P};

  function automatic logic [7:0] to_bcd(input int unsigned v);
    int unsigned c;
    c = (v > 32'd99) ? 32'd99 : v;
    return {4'(c / 10), 4'(c % 10)};
  endfunction

  // Two-digit BCD increment that sticks at 99 rather than wrapping.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic char_t tens_char(input logic [3:0] d);
    return (d == 4'd0) ? CH_SPACE : {2'b00, d};
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score register with synchronous clear and a saturating increment.
module bcd_score_counter
  import pong_chars_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] score
);

  logic [7:0] score_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      score_reg <= 8'h00;
    else if (clr)
      score_reg <= 8'h00;
    else if (inc)
      score_reg <= bcd_inc(score_reg);
  end

  assign score = score_reg;

endmodule

// File: rtl/score_banner_ctrl.sv
// Game-level sequencer for the 8-slot character row: title, live scores, scorer flash, win banner.
// Optional BANNER_BLINK_EN: the whole win banner blinks instead of holding steady.
module score_banner_ctrl
  import pong_chars_pkg::*;
#(
  parameter int WIN_SCORE    = 11,
  parameter int FLASH_FRAMES = 30,
  parameter int BLINK_PERIOD = 8,
  parameter int HOLD_FRAMES  = 180
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_tick,
  input  logic                        start,
  input  logic                        point_p1,
  input  logic                        point_p2,
  output logic [NUM_SLOTS*CODE_W-1:0] char_codes,
  output logic [NUM_SLOTS-1:0]        slot_visible,
  output logic [7:0]                  score_p1,
  output logic [7:0]                  score_p2,
  output logic                        game_over,
  output logic                        busy
);

  localparam logic [7:0] WIN_BCD    = to_bcd(WIN_SCORE);
  localparam logic [9:0] FLASH_LAST = 10'(FLASH_FRAMES - 1);
  localparam logic [9:0] HOLD_LAST  = 10'(HOLD_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_PERIOD - 1);

  state_t     state_reg, state_next;
  logic [9:0] frame_cnt_reg, frame_cnt_next;
  logic [7:0] blink_cnt_reg, blink_cnt_next;
  logic       blink_off_reg, blink_off_next;
  logic       scorer_reg, scorer_next;   // 0 = player 1, 1 = player 2; doubles as the winner
  logic       clr_scores, inc_p1, inc_p2;
  logic [7:0] score_p1_val, score_p2_val;

  logic [NUM_SLOTS*CODE_W-1:0] codes_next;
  logic [NUM_SLOTS-1:0]        vis_next;
  logic                        game_over_next, busy_next;
  logic                        game_over_reg, busy_reg;

  bcd_score_counter u_score_p1 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_scores),
    .inc   (inc_p1),
    .score (score_p1_val)
  );

  bcd_score_counter u_score_p2 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_scores),
    .inc   (inc_p2),
    .score (score_p2_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      frame_cnt_reg <= '0;
      blink_cnt_reg <= '0;
      blink_off_reg <= 1'b0;
      scorer_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      blink_cnt_reg <= blink_cnt_next;
      blink_off_reg <= blink_off_next;
      scorer_reg    <= scorer_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    scorer_next = scorer_reg;
    clr_scores  = 1'b0;
    inc_p1      = 1'b0;
    inc_p2      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = PLAY;
          clr_scores = 1'b1;
        end
      end
      PLAY: begin
        // Player 1 wins a same-cycle tie; player 2's point is dropped.
        if (point_p1) begin
          inc_p1      = 1'b1;
          scorer_next = 1'b0;
          state_next  = (bcd_inc(score_p1_val) == WIN_BCD) ? WIN : FLASH;
        end else if (point_p2) begin
          inc_p2      = 1'b1;
          scorer_next = 1'b1;
          state_next  = (bcd_inc(score_p2_val) == WIN_BCD) ? WIN : FLASH;
        end
      end
      FLASH: begin
        if (frame_tick && frame_cnt_reg == FLASH_LAST)
          state_next = PLAY;
      end
      WIN: begin
        if (frame_tick && frame_cnt_reg == HOLD_LAST)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Counters restart on every state entry; a tick landing on the entry cycle is dropped.
    frame_cnt_next = frame_cnt_reg;
    blink_cnt_next = blink_cnt_reg;
    blink_off_next = blink_off_reg;
    if (state_next != state_reg) begin
      frame_cnt_next = '0;
      blink_cnt_next = '0;
      blink_off_next = 1'b0;
    end else if (frame_tick && (state_reg == FLASH || state_reg == WIN)) begin
      frame_cnt_next = frame_cnt_reg + 10'd1;
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_next = '0;
        blink_off_next = ~blink_off_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 8'd1;
      end
    end
  end

  always_comb begin
    codes_next     = TITLE_CODES;
    vis_next       = '1;
    game_over_next = 1'b0;
    busy_next      = 1'b0;
    case (state_reg)
      PLAY, FLASH: begin
        codes_next = {{2'b00, score_p2_val[3:0]}, tens_char(score_p2_val[7:4]),
                      {4{CH_SPACE}},
                      {2'b00, score_p1_val[3:0]}, tens_char(score_p1_val[7:4])};
        if (state_reg == FLASH) begin
          busy_next = 1'b1;
          if (blink_off_reg) begin
            if (scorer_reg)
              vis_next[7:6] = 2'b00;
            else
              vis_next[1:0] = 2'b00;
          end
        end
      end
      WIN: begin
        codes_next     = scorer_reg ? WIN_P2_CODES : WIN_P1_CODES;
        game_over_next = 1'b1;
        busy_next      = 1'b1;
`ifdef BANNER_BLINK_EN
        if (blink_off_reg)
          vis_next = '0;
`endif
      end
      default: ;
    endcase
  end

  // One code/visibility register pair per glyph renderer slot.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic [CODE_W-1:0] code_reg;
    logic              vis_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        code_reg <= TITLE_CODES[gi*CODE_W +: CODE_W];
        vis_reg  <= 1'b1;
      end else begin
        code_reg <= codes_next[gi*CODE_W +: CODE_W];
        vis_reg  <= vis_next[gi];
      end
    end

    assign char_codes[gi*CODE_W +: CODE_W] = code_reg;
    assign slot_visible[gi]                = vis_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      game_over_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      game_over_reg <= game_over_next;
      busy_reg      <= busy_next;
    end
  end

  assign game_over = game_over_reg;
  assign busy      = busy_reg;
  assign score_p1  = score_p1_val;
  assign score_p2  = score_p2_val;

endmodule

// File: tb/tb_score_banner_ctrl.sv
// Randomized self-checking bench for score_banner_ctrl against an integer game model.
module tb_score_banner_ctrl;

  localparam int WIN_S   = 11;
  localparam int FLASH_F = 30;
  localparam int BLINK_P = 8;
  localparam int HOLD_F  = 180;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_FLASH = 2;
  localparam int M_WIN   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        point_p1 = 1'b0;
  logic        point_p2 = 1'b0;
  logic [47:0] char_codes;
  logic [7:0]  slot_visible;
  logic [7:0]  score_p1;
  logic [7:0]  score_p2;
  logic        game_over;
  logic        busy;

  score_banner_ctrl #(
    .WIN_SCORE    (WIN_S),
    .FLASH_FRAMES (FLASH_F),
    .BLINK_PERIOD (BLINK_P),
    .HOLD_FRAMES  (HOLD_F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .point_p1     (point_p1),
    .point_p2     (point_p2),
    .char_codes   (char_codes),
    .slot_visible (slot_visible),
    .score_p1     (score_p1),
    .score_p2     (score_p2),
    .game_over    (game_over),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Model: game mode, integer scores, who scored last, frame ticks since entering the mode.
  int m_mode, m_s1, m_s2, m_who, m_ticks;

  int title_c[8] = '{36, 25, 24, 23, 16, 36, 36, 36};
  int win_c[8]   = '{25, 1, 36, 32, 18, 23, 28, 36};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic reset_model();
    m_mode  = M_IDLE;
    m_s1    = 0;
    m_s2    = 0;
    m_who   = 0;
    m_ticks = 0;
  endtask

  task automatic check_all();
    int exp_code[8];
    int exp_vis;
    if (m_mode == M_IDLE) begin
      exp_code = title_c;
    end else if (m_mode == M_WIN) begin
      exp_code    = win_c;
      exp_code[1] = m_who;
    end else begin
      for (int k = 0; k < 8; k++) exp_code[k] = 36;
      exp_code[0] = (m_s1 / 10 == 0) ? 36 : m_s1 / 10;
      exp_code[1] = m_s1 % 10;
      exp_code[6] = (m_s2 / 10 == 0) ? 36 : m_s2 / 10;
      exp_code[7] = m_s2 % 10;
    end
    exp_vis = 'hFF;
    if (m_mode == M_FLASH && ((m_ticks / BLINK_P) % 2 == 1))
      exp_vis = (m_who == 1) ? 'hFC : 'h3F;
`ifdef BANNER_BLINK_EN
    if (m_mode == M_WIN && ((m_ticks / BLINK_P) % 2 == 1))
      exp_vis = 'h00;
`endif
    for (int k = 0; k < 8; k++)
      check_eq($sformatf("slot%0d_code", k), 64'(char_codes[6*k +: 6]), 64'(exp_code[k]));
    check_eq("slot_visible", 64'(slot_visible), 64'(exp_vis));
    check_eq("score_p1", 64'(score_p1), 64'(bcd(m_s1)));
    check_eq("score_p2", 64'(score_p2), 64'(bcd(m_s2)));
    check_eq("game_over", 64'(game_over), 64'(m_mode == M_WIN));
    check_eq("busy", 64'(busy), 64'(m_mode == M_FLASH || m_mode == M_WIN));
  endtask

  task automatic model_point(input int who);
    if (who == 1) m_s1 = (m_s1 < 99) ? m_s1 + 1 : 99;
    else          m_s2 = (m_s2 < 99) ? m_s2 + 1 : 99;
    m_who   = who;
    m_mode  = (((who == 1) ? m_s1 : m_s2) == WIN_S) ? M_WIN : M_FLASH;
    m_ticks = 0;
  endtask

  // One transaction: a single-cycle pulse set, settle two edges, update model, compare.
  task automatic txn(input string name, input logic t, input logic s, input logic a, input logic b);
    @(negedge clk);
    frame_tick = t; start = s; point_p1 = a; point_p2 = b;
    @(negedge clk);
    frame_tick = 1'b0; start = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
    @(negedge clk);
    case (m_mode)
      M_IDLE: if (s) begin
        m_mode = M_PLAY; m_s1 = 0; m_s2 = 0; m_ticks = 0;
      end
      M_PLAY: begin
        if (a)      model_point(1);
        else if (b) model_point(2);
      end
      default: if (t) begin
        m_ticks++;
        if (m_mode == M_FLASH && m_ticks == FLASH_F) begin
          m_mode = M_PLAY; m_ticks = 0;
        end else if (m_mode == M_WIN && m_ticks == HOLD_F) begin
          m_mode = M_IDLE; m_ticks = 0;
        end
      end
    endcase
    n_txn++;
    $display("txn %0d %s t=%0b s=%0b p1=%0b p2=%0b -> mode=%0d score=%0d:%0d ticks=%0d",
             n_txn, name, t, s, a, b, m_mode, m_s1, m_s2, m_ticks);
    check_all();
  endtask

  // Run ticks (with occasional ignored pulses) until FLASH or WIN has finished.
  task automatic wait_out(input string what);
    for (int i = 0; i < 400 && m_mode != M_PLAY && m_mode != M_IDLE; i++) begin
      if ($urandom_range(0, 9) == 0)
        txn("busy_noise", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      else
        txn(what, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic random_game();
    int r;
    txn("rnd_start", 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4000 && m_mode != M_IDLE; i++) begin
      r = int'($urandom_range(0, 15));
      if (m_mode == M_PLAY) begin
        if (r < 6)       txn("rnd_p1", 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
        else if (r < 12) txn("rnd_p2", 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
        else if (r < 14) txn("rnd_both", 1'b0, 1'b0, 1'b1, 1'b1);
        else if (r == 14) txn("rnd_tick", 1'b1, 1'b0, 1'b0, 1'b0);
        else             txn("rnd_start_play", 1'b0, 1'b1, 1'b0, 1'b0);
      end else if (r == 0) begin
        txn("rnd_noise", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        txn("rnd_tick", 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_txn++;
    $display("txn %0d reset_release", n_txn);
    check_all();

    txn("idle_point", 1'b0, 1'b0, 1'b1, 1'b0);
    txn("idle_point_tick", 1'b1, 1'b0, 1'b0, 1'b1);
    txn("start", 1'b0, 1'b1, 1'b0, 1'b0);

    // Same-cycle points: player 1 scores, player 2 dropped, further points ignored.
    txn("both_points", 1'b0, 1'b0, 1'b1, 1'b1);
    txn("flash_point", 1'b0, 1'b0, 1'b0, 1'b1);
    wait_out("flash_tick");
    repeat (9) begin
      txn("p1_point", 1'b0, 1'b0, 1'b1, 1'b0);
      wait_out("flash_tick");
    end
    repeat (11) begin
      txn("p2_point", 1'b0, 1'b0, 1'b0, 1'b1);
      wait_out("flash_or_hold_tick");
    end
    txn("idle_after_win", 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (2) random_game();

    // Reset in the middle of a flash at 3:5.
    txn("start", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      txn("p1_point", 1'b0, 1'b0, 1'b1, 1'b0);
      wait_out("flash_tick");
    end
    repeat (4) begin
      txn("p2_point", 1'b0, 1'b0, 1'b0, 1'b1);
      wait_out("flash_tick");
    end
    txn("p2_point", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) txn("flash_tick", 1'b1, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    reset_model();
    n_txn++;
    $display("txn %0d reset_mid_flash", n_txn);
    check_all();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_txn++;
    $display("txn %0d reset_release_after_flash", n_txn);
    check_all();
    txn("start_after_reset", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
